// File: rtl/fifo_gen2.sv
// Synchronous FIFO with arbitrary depth, occupancy/high-watermark outputs,
// programmable almost-full/almost-empty flags and a synchronous flush.
module fifo_gen2 #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 5,
   parameter int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int AE_LEVEL   = 1,
   localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  push_valid_i,
   output logic                  push_grant_o,
   input  logic                  pop_grant_i,
   output logic [DATA_WIDTH-1:0] pop_data_o,
   output logic                  pop_valid_o,
   output logic [CW-1:0]         count_o,
   output logic [CW-1:0]         max_count_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C       = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C       = CW'(AE_LEVEL);
   localparam logic [PW-1:0] LAST_PTR_C = PW'(FIFO_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         max_q;
   logic [CW-1:0]         count_next;
   logic [CW-1:0]         max_next;
   logic [PW-1:0]         wr_ptr_next;
   logic [PW-1:0]         rd_ptr_next;
   logic                  push;
   logic                  pop;

   // Everything visible at the ports derives from registered state only.
   assign push_grant_o   = (count_q != DEPTH_C);
   assign pop_valid_o    = (count_q != '0);
   assign pop_data_o     = pop_valid_o ? mem[rd_ptr] : '0;
   assign count_o        = count_q;
   assign max_count_o    = max_q;
   assign almost_full_o  = (count_q >= AF_C);
   assign almost_empty_o = (count_q <= AE_C);

   assign push = push_valid_i & push_grant_o;
   assign pop  = pop_valid_o & pop_grant_i;

   always_comb begin
      wr_ptr_next = (wr_ptr == LAST_PTR_C) ? '0 : wr_ptr + 1'b1;
      rd_ptr_next = (rd_ptr == LAST_PTR_C) ? '0 : rd_ptr + 1'b1;
      count_next  = count_q;
      if (push && !pop) begin
         count_next = count_q + 1'b1;
      end else if (pop && !push) begin
         count_next = count_q - 1'b1;
      end
      max_next = (count_next > max_q) ? count_next : max_q;
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         max_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr_next;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_next;
         end
         count_q <= count_next;
         max_q   <= max_next;
      end
   end

   // Storage is never cleared; reset and flush only suppress the write.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i && push) begin
         mem[wr_ptr] <= push_data_i;
      end
   end

endmodule

// File: doc/fifo_gen2.md
# fifo_gen2

Parametrised synchronous FIFO, the second-generation buffer for push/pop valid-grant links in the datapath. It adds several features over the first-generation buffer: arbitrary (non-power-of-two) depth, exact data width, occupancy and high-watermark outputs, programmable almost-full/almost-empty flags, and a synchronous flush. It sits between any producer and consumer that use the push_valid/push_grant and pop_valid/pop_grant handshake.

## Interface
- DATA_WIDTH, 32, payload width in bits (exact, no extra bit)
- FIFO_DEPTH, 5, number of entries; any integer ≥ 2
- AF_LEVEL, FIFO_DEPTH-1, almost_full_o asserts when count ≥ AF_LEVEL (1..FIFO_DEPTH)
- AE_LEVEL, 1, almost_empty_o asserts when count ≤ AE_LEVEL (0..FIFO_DEPTH-1)
- CW (local), $clog2(FIFO_DEPTH+1), width of count/watermark outputs
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset; synchronous, active-high
- flush_i  in  1  synchronous empty request
- push_data_i  in  DATA_WIDTH  write data
- push_valid_i  in  1  producer has data
- push_grant_o  out  1  FIFO can accept data this cycle
- pop_grant_i  in  1  consumer takes data this cycle
- pop_data_o  out  DATA_WIDTH  head entry
- pop_valid_o  out  1  head entry valid
- count_o  out  CW  current occupancy
- max_count_o  out  CW  highest occupancy since reset/flush
- almost_full_o  out  1  count_o ≥ AF_LEVEL
- almost_empty_o  out  1  count_o ≤ AE_LEVEL

## Operation
- Storage: FIFO_DEPTH × DATA_WIDTH array. Contents are not reset or cleared.
- Pointers wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits wide. Each advances by 1 and wraps from FIFO_DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- push = push_valid_i & push_grant_o; pop = pop_valid_o & pop_grant_i.
- push_grant_o = (count_o != FIFO_DEPTH). When full, no push is accepted, even if a pop occurs in the same cycle.
- pop_valid_o = (count_o != 0). There is no empty-bypass: pushed data is never visible at the output in the same cycle.
- pop_data_o = mem[rd_ptr] when pop_valid_o is high; forced to 0 when empty.
- Count update: push only → +1; pop only → −1; both or neither → unchanged. Count never exceeds FIFO_DEPTH and never underflows.
- Simultaneous push and pop when count=1: the write and the read target different entries. Next cycle, the head is the newly pushed word.
- max_count_o ← max(max_count_o, next count) every cycle.
- Flush (flush_i=1): on the next edge, wr_ptr=rd_ptr=0, count=0, max_count=0. Push and pop in that same cycle are ignored (no pointer movement, no write). Handshake outputs still follow the current count during the flush cycle.
- Priority at each edge: rst > flush_i > push/pop.

## Timing
- Reset values, visible the cycle after rst is sampled high: count_o=0, max_count_o=0, pop_valid_o=0, pop_data_o=0, push_grant_o=1, almost_empty_o=1 (for AE_LEVEL ≥ 0), almost_full_o=0.
- Reset asserted mid-traffic: all in-flight contents are discarded. The first push after rst deasserts lands at entry 0.
- Push→pop latency: data pushed at edge N is presented with pop_valid_o=1 in cycle N+1.
- All flags and grants are combinational from registered state only, never from same-cycle inputs. There are no combinational paths from inputs to outputs.
- Full throughput: one push and one pop per cycle sustained when 0 < count < FIFO_DEPTH.
- almost_full_o and almost_empty_o change in the same cycle as count_o.

## Test plan
- Reset/idle: DEPTH=5, W=8; hold rst 2 cycles → count_o=0, pop_valid_o=0, pop_data_o=0x00, push_grant_o=1, almost_empty_o=1.
- Fill/drain with wrap: push 0x01..0x05 with pop_grant_i=0 → push_grant_o=0 and count_o=5 after the 5th push; push 0x06 is refused. Pop 3, push 0x06..0x08, pop all → output order 01..08; wr_ptr has wrapped 4→0.
- Simultaneous push/pop: at count=1 (head 0xA0), push 0xB0 and pop in the same cycle → 0xA0 consumed, count_o stays 1, next head 0xB0. At count=5, push+pop → push refused, count_o=4.
- Flags/watermark: AF_LEVEL=4, AE_LEVEL=1; push 4 → almost_full_o=1 at count 4 and max_count_o=4; pop 3 → almost_empty_o=1 at count 1 and max_count_o still 4.
- Flush: count=3; assert flush_i together with push 0x55 and pop → next cycle count_o=0, max_count_o=0, pop_valid_o=0. The next push 0x66 then pops as 0x66.
- Reset mid-operation: count=4, rst pulsed 1 cycle with push_valid_i=1 → count_o=0, and the old data is never popped.
